// File: rtl/derotate_seq.sv
// Sequential inverse rotator for 4-bit data: undoes a left/right rotate of 0-3 bits.
// Optional DEROTATE_FAST_EN selects a single-cycle barrel version instead of one bit per cycle.
module derotate_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] data_in,
  input  logic [3:0] cmd,
  output logic [7:0] result,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic       accept_s;
  logic [3:0] work_r;
  logic [3:0] res_r;
  logic [1:0] cnt_r;
  logic       dir_r;
  logic       busy_r;
  logic       done_r;

  // dir=0 means the original rotation was left, so undo it by rotating right
  function automatic logic [3:0] step_inv(input logic [3:0] d, input logic dir);
    logic [3:0] r;
    if (dir == 1'b0) begin
      r = {d[0], d[3:1]};
    end else begin
      r = {d[2:0], d[3]};
    end
    return r;
  endfunction

`ifdef DEROTATE_FAST_EN
  function automatic logic [3:0] barrel_inv(input logic [3:0] d, input logic [1:0] amt,
                                            input logic dir);
    logic [7:0] dd;
    logic [7:0] sh;
    logic [3:0] r;
    dd = {d, d};
    if (dir == 1'b0) begin
      sh = dd >> amt;
      r  = sh[3:0];
    end else begin
      sh = dd << amt;
      r  = sh[7:4];
    end
    return r;
  endfunction
`endif

  // next-state decode
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start == 1'b1) begin
          accept_s = 1'b1;
`ifdef DEROTATE_FAST_EN
          state_nx_s = DONE;
`else
          if (cmd[1:0] == 2'd0) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = SHIFT;
          end
`endif
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == 2'd1) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // state, datapath and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= 4'd0;
      res_r   <= 4'd0;
      cnt_r   <= 2'd0;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SHIFT);
      done_r  <= (state_nx_s == DONE);
      if (accept_s) begin
        work_r <= data_in;
        dir_r  <= cmd[3];
`ifdef DEROTATE_FAST_EN
        cnt_r  <= 2'd0;
        res_r  <= barrel_inv(data_in, cmd[1:0], cmd[3]);
`else
        cnt_r  <= cmd[1:0];
        if (cmd[1:0] == 2'd0) begin
          res_r <= data_in;
        end else begin
          res_r <= res_r;
        end
`endif
      end else if (state_r == SHIFT) begin
        work_r <= step_inv(work_r, dir_r);
        cnt_r  <= cnt_r - 2'd1;
        // last shift lands directly in the result register on entry to DONE
        if (cnt_r == 2'd1) begin
          res_r <= step_inv(work_r, dir_r);
        end else begin
          res_r <= res_r;
        end
      end else begin
        work_r <= work_r;
        cnt_r  <= cnt_r;
        res_r  <= res_r;
      end
    end
  end

  assign result = {4'b0000, res_r};
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_derotate_seq.sv
// Self-checking bench for derotate_seq: directed cases plus random operations against
// an arithmetic model of the inverse rotation, latency and busy behaviour.
module tb_derotate_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] data_in;
  logic [3:0] cmd;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_res;

  derotate_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .cmd     (cmd),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inverse rotation from the arithmetic definition: net right-rotate amount, modulo 4.
  function automatic logic [3:0] model(input logic [3:0] d, input logic [3:0] c);
    int a;
    int sh;
    int v;
    a  = int'(c[1:0]);
    sh = c[3] ? (4 - a) % 4 : a;
    v  = int'(d);
    v  = ((v >> sh) | (v << (4 - sh))) & 15;
    return v[3:0];
  endfunction

  function automatic int exp_latency(input logic [3:0] c);
`ifdef DEROTATE_FAST_EN
    return 1;
`else
    return int'(c[1:0]) + 1;
`endif
  endfunction

  // Called at posedge+1 with the DUT in IDLE or DONE. Returns at posedge+1 just after done rises.
  task automatic run_op(input string tag, input logic [3:0] d, input logic [3:0] c,
                        input int poke);
    int k;
    int lat;
    logic [7:0] exp_res;
    lat     = exp_latency(c);
    exp_res = {4'h0, model(d, c)};
    start   = 1'b1;
    data_in = d;
    cmd     = c;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 8) begin
      chk({tag, "_busy"}, {7'd0, busy}, {7'd0, (k < lat) ? 1'b1 : 1'b0});
      chk({tag, "_hold"}, result, prev_res);
      if (k == poke) begin
        start   = 1'b1;
        data_in = ~d;
        cmd     = 4'b0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    chk({tag, "_lat"}, k[7:0], lat[7:0]);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_busy_done"}, {7'd0, busy}, 8'd0);
    prev_res = exp_res;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {7'd0, done}, 8'd0);
    chk({tag, "_res_held"}, result, prev_res);
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] c;
    int poke;

    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = 4'h0;
    cmd      = 4'h0;
    prev_res = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("d0110_c0001", 4'b0110, 4'b0001, 0);
    chk("c1_value", result, 8'h03);
    idle_cycle("c1");

    run_op("d1001_c1010", 4'b1001, 4'b1010, 0);
    chk("c2_value", result, 8'h06);
    idle_cycle("c2");

    run_op("d0001_c0011_poke", 4'b0001, 4'b0011, 1);
    chk("c3_value", result, 8'h02);
    idle_cycle("c3");

    run_op("d1010_c0100", 4'b1010, 4'b0100, 0);
    chk("c4_value", result, 8'h0a);
    run_op("b2b_d0110_c0001", 4'b0110, 4'b0001, 0);
    chk("c4b_value", result, 8'h03);
    idle_cycle("c4b");

    // reset at the second edge of an operation aborts it
    start   = 1'b1;
    data_in = 4'b1011;
    cmd     = 4'b0011;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    prev_res = 8'h00;
    chk("abort_result", result, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {7'd0, done}, 8'd0);
      chk("abort_no_busy", {7'd0, busy}, 8'd0);
    end

    for (int i = 0; i < 30; i++) begin
      d    = 4'($urandom);
      c    = 4'($urandom);
      poke = $urandom_range(0, 3);
      if (poke > int'(c[1:0])) poke = 0;
      run_op("rand", d, c, poke);
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end

    // reset while in DONE with start high: reset wins
    run_op("pre_rst", 4'b1100, 4'b1001, 0);
    start   = 1'b1;
    data_in = 4'b0101;
    cmd     = 4'b0000;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    prev_res = 8'h00;
    chk("rst_prio_result", result, 8'h00);
    chk("rst_prio_done", {7'd0, done}, 8'd0);
    chk("rst_prio_busy", {7'd0, busy}, 8'd0);
    idle_cycle("rst_prio");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
